filter_peak_detector: RTL and testbench

- Downstream stage of the trapezoidal shaping filter; consumes its per-clock filtered sample stream.
- Detects pulses by threshold crossing, tracks the pulse maximum, and emits one event per pulse: amplitude, timestamp of maximum, and flags.
- Events leave through a one-entry valid/ready output register toward the readout/histogram logic.
- Counts events dropped because the output register was still occupied.

---
 rtl/package_settings.sv | 7 +
 rtl/peak_detector_parameters.sv | 37 +++
 rtl/peak_event_buffer.sv | 37 +++
 rtl/filter_peak_detector.sv | 135 +++++++++++++
 tb/tb_filter_peak_detector.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/package_settings.sv
// Shared settings for the pulse-processing chain.
// Sample width of the trapezoidal filter output.
package package_settings;

    localparam int SIZE_FILTER_DATA = 16;

endpackage

// File: rtl/peak_detector_parameters.sv
// Peak detector constants, FSM state type and event bundle.
// Imported by the detector and its output buffer.
package peak_detector_parameters;

    import package_settings::*;

    localparam int TS_WIDTH   = 32;
    localparam int MAX_WIDTH  = 64;
    localparam int HOLDOFF    = 16;
    localparam int LOST_WIDTH = 16;

    // Width counter must reach MAX_WIDTH and still feed an 8-bit field
    localparam int CNT_W  = ($clog2(MAX_WIDTH + 1) > 8) ? $clog2(MAX_WIDTH + 1) : 8;
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_WAIT_LOW,
        ST_HOLDOFF
    } state_t;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic [TS_WIDTH-1:0]                ts;
        logic [7:0]                         width;
        logic                               trunc;
    } event_t;

    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] w);
        if (|(w >> 8)) begin
            return 8'hff;
        end
        return w[7:0];
    endfunction

endpackage

// File: rtl/peak_event_buffer.sv
// One-entry valid/ready event register with saturating drop counter.
// A push into a full, non-accepting register is dropped and counted.
module peak_event_buffer
    import peak_detector_parameters::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  event_t                ev,
    input  logic                  ready,
    output logic                  valid,
    output event_t                slot,
    output logic [LOST_WIDTH-1:0] lost_cnt
);

    logic accept;

    assign accept = valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            slot     <= '0;
            lost_cnt <= '0;
        end else if (push) begin
            if (!valid || accept) begin
                valid <= 1'b1;
                slot  <= ev;
            end else if (lost_cnt != '1) begin
                lost_cnt <= lost_cnt + LOST_WIDTH'(1);
            end
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/filter_peak_detector.sv
// Threshold-triggered peak detector on the filtered sample stream.
// Emits one event per pulse: peak amplitude, peak timestamp, width, flags.
module filter_peak_detector
    import package_settings::*;
    import peak_detector_parameters::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    output logic                               ev_valid,
    input  logic                               ev_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] ev_amp,
    output logic [TS_WIDTH-1:0]                ev_ts,
    output logic [7:0]                         ev_width,
    output logic                               ev_trunc,
    output logic [LOST_WIDTH-1:0]              lost_cnt,
    output logic                               busy
);

    localparam state_t AFTER_LOW = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;

    state_t                             state, state_nxt;
    logic [TS_WIDTH-1:0]                ts;
    logic signed [SIZE_FILTER_DATA-1:0] peak, peak_nxt;
    logic [TS_WIDTH-1:0]                peak_ts, peak_ts_nxt;
    logic [CNT_W-1:0]                   width, width_nxt;
    logic [HOLD_W-1:0]                  hold_cnt, hold_cnt_nxt;
    logic                               above;
    logic                               push;
    logic                               trunc;
    event_t                             ev;
    event_t                             slot;

    assign above = filter_data > threshold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ts       <= '0;
            peak     <= '0;
            peak_ts  <= '0;
            width    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ts       <= ts + TS_WIDTH'(1);
            peak     <= peak_nxt;
            peak_ts  <= peak_ts_nxt;
            width    <= width_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        peak_nxt     = peak;
        peak_ts_nxt  = peak_ts;
        width_nxt    = width;
        hold_cnt_nxt = hold_cnt;
        push         = 1'b0;
        trunc        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (above) begin
                    peak_nxt    = filter_data;
                    peak_ts_nxt = ts;
                    width_nxt   = CNT_W'(1);
                    if (MAX_WIDTH <= 1) begin
                        push      = 1'b1;
                        trunc     = 1'b1;
                        state_nxt = ST_WAIT_LOW;
                    end else begin
                        state_nxt = ST_TRACK;
                    end
                end
            end
            ST_TRACK: begin
                if (above) begin
                    width_nxt = width + CNT_W'(1);
                    // strict compare keeps the earliest of equal maxima
                    if (filter_data > peak) begin
                        peak_nxt    = filter_data;
                        peak_ts_nxt = ts;
                    end
                    if (width_nxt == CNT_W'(MAX_WIDTH)) begin
                        push      = 1'b1;
                        trunc     = 1'b1;
                        state_nxt = ST_WAIT_LOW;
                    end
                end else begin
                    push         = 1'b1;
                    hold_cnt_nxt = '0;
                    state_nxt    = AFTER_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!above) begin
                    hold_cnt_nxt = '0;
                    state_nxt    = AFTER_LOW;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt == HOLD_W'(HOLDOFF - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        ev.amp   = peak_nxt;
        ev.ts    = peak_ts_nxt;
        ev.width = sat8(width_nxt);
        ev.trunc = trunc;
    end

    peak_event_buffer u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .ev       (ev),
        .ready    (ev_ready),
        .valid    (ev_valid),
        .slot     (slot),
        .lost_cnt (lost_cnt)
    );

    assign ev_amp   = slot.amp;
    assign ev_ts    = slot.ts;
    assign ev_width = slot.width;
    assign ev_trunc = slot.trunc;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_filter_peak_detector.sv
// Directed bench for filter_peak_detector with a pulse-level reference model.
// Model compares every cycle; literal checks pin the model on key vectors.
module tb_filter_peak_detector;

    import package_settings::*;
    import peak_detector_parameters::*;

    logic                               clk;
    logic                               reset;
    logic signed [SIZE_FILTER_DATA-1:0] filter_data;
    logic signed [SIZE_FILTER_DATA-1:0] threshold;
    logic                               ev_valid;
    logic                               ev_ready;
    logic signed [SIZE_FILTER_DATA-1:0] ev_amp;
    logic [TS_WIDTH-1:0]                ev_ts;
    logic [7:0]                         ev_width;
    logic                               ev_trunc;
    logic [LOST_WIDTH-1:0]              lost_cnt;
    logic                               busy;

    filter_peak_detector dut (
        .clk         (clk),
        .reset       (reset),
        .filter_data (filter_data),
        .threshold   (threshold),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_amp      (ev_amp),
        .ev_ts       (ev_ts),
        .ev_width    (ev_width),
        .ev_trunc    (ev_trunc),
        .lost_cnt    (lost_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 0;

    // Reference model: pulse tracking plus timestamp at which input re-arms
    int m_ts, m_pk, m_pts, m_w, m_arm;
    bit m_trk, m_wl;
    bit m_v, m_etr;
    int m_amp, m_ets, m_ew, m_lost;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return m_trk || m_wl || (m_ts < m_arm);
    endfunction

    task automatic model(input int d, input int thr, input bit rdy, input bit rst);
        bit above, push, tr, acc;
        if (rst) begin
            m_ts = 0; m_trk = 0; m_wl = 0; m_arm = 0;
            m_pk = 0; m_pts = 0; m_w = 0;
            m_v = 0; m_amp = 0; m_ets = 0; m_ew = 0; m_etr = 0; m_lost = 0;
            return;
        end
        above = d > thr;
        push = 0;
        tr = 0;
        if (m_trk) begin
            if (above) begin
                m_w++;
                if (d > m_pk) begin
                    m_pk = d;
                    m_pts = m_ts;
                end
                if (m_w == MAX_WIDTH) begin
                    push = 1; tr = 1; m_trk = 0; m_wl = 1;
                end
            end else begin
                push = 1; m_trk = 0; m_arm = m_ts + HOLDOFF + 1;
            end
        end else if (m_wl) begin
            if (!above) begin
                m_wl = 0; m_arm = m_ts + HOLDOFF + 1;
            end
        end else if (above && m_ts >= m_arm) begin
            m_trk = 1; m_pk = d; m_pts = m_ts; m_w = 1;
        end
        acc = m_v && rdy;
        if (push) begin
            if (!m_v || acc) begin
                m_v = 1; m_amp = m_pk; m_ets = m_pts;
                m_ew = (m_w > 255) ? 255 : m_w;
                m_etr = tr;
            end else if (m_lost < (1 << LOST_WIDTH) - 1) begin
                m_lost++;
            end
        end else if (acc) begin
            m_v = 0;
        end
        m_ts++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ev_valid", ev_valid, m_v);
            chk("lost_cnt", lost_cnt, m_lost);
            chk("busy", busy, m_busy());
            if (m_v) begin
                chk("ev_amp", ev_amp, m_amp);
                chk("ev_ts", ev_ts, m_ets);
                chk("ev_width", ev_width, m_ew);
                chk("ev_trunc", ev_trunc, m_etr);
            end
        end
    end

    task automatic step(input int d, input int thr, input bit rdy, input bit rst);
        filter_data = SIZE_FILTER_DATA'(d);
        threshold   = SIZE_FILTER_DATA'(thr);
        ev_ready    = rdy;
        reset       = rst;
        @(posedge clk);
        model(d, thr, rdy, rst);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(0, 100, 0, 1);
        step(0, 100, 0, 1);
        chk_en = 1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 100, rdy, 0);
    endtask

    task automatic pulse(input int amp, input int len, input bit rdy_fall);
        for (int i = 0; i < len; i++) step(amp, 100, 0, 0);
        step(0, 100, rdy_fall, 0);
    endtask

    initial begin
        reset = 1'b1;
        filter_data = '0;
        threshold = '0;
        ev_ready = 1'b0;

        // Single pulse with a repeated maximum
        do_reset();
        chk("rst_valid", ev_valid, 0);
        chk("rst_busy", busy, 0);
        step(0, 100, 0, 0);
        step(50, 100, 0, 0);
        step(150, 100, 0, 0);
        step(300, 100, 0, 0);
        step(300, 100, 0, 0);
        step(120, 100, 0, 0);
        chk("p1_not_yet", ev_valid, 0);
        step(80, 100, 0, 0);
        chk("p1_valid", ev_valid, 1);
        chk("p1_amp", ev_amp, 300);
        chk("p1_ts", ev_ts, 3);
        chk("p1_width", ev_width, 4);
        chk("p1_trunc", ev_trunc, 0);
        idle(20, 1);

        // Long pulse truncated at MAX_WIDTH
        do_reset();
        idle(10, 0);
        for (int i = 0; i < 100; i++) begin
            step(500, 100, 0, 0);
            if (i == MAX_WIDTH - 2) chk("long_early", ev_valid, 0);
            if (i == MAX_WIDTH - 1) begin
                chk("long_valid", ev_valid, 1);
                chk("long_width", ev_width, 64);
                chk("long_trunc", ev_trunc, 1);
                chk("long_ts", ev_ts, 10);
                chk("long_amp", ev_amp, 500);
            end
        end
        idle(20, 0);
        chk("long_lost", lost_cnt, 0);
        idle(2, 1);
        chk("long_drained", ev_valid, 0);

        // Backpressure: three pulses, first kept, two dropped
        do_reset();
        pulse(200, 3, 0);
        idle(20, 0);
        pulse(400, 3, 0);
        idle(20, 0);
        pulse(600, 3, 0);
        idle(20, 0);
        chk("bp_amp", ev_amp, 200);
        chk("bp_lost", lost_cnt, 2);
        step(0, 100, 1, 0);
        chk("bp_accept", ev_valid, 0);
        idle(2, 0);

        // Accept and emit in the same clk
        do_reset();
        pulse(200, 3, 0);
        idle(20, 0);
        pulse(333, 2, 1);
        chk("sim_valid", ev_valid, 1);
        chk("sim_amp", ev_amp, 333);
        chk("sim_lost", lost_cnt, 0);
        idle(20, 1);

        // Hold-off: rise at fall+5 ignored, rise at fall+17 detected
        do_reset();
        pulse(250, 3, 0);
        idle(4, 1);
        pulse(250, 3, 0);
        chk("ho_ignored", ev_valid, 0);
        chk("ho_busy", busy, 1);
        idle(8, 0);
        pulse(260, 2, 0);
        chk("ho_valid", ev_valid, 1);
        chk("ho_amp", ev_amp, 260);
        chk("ho_ts", ev_ts, 20);
        idle(20, 1);

        // Signed compare, equal-to-threshold is not above
        do_reset();
        step(-100, -50, 1, 0);
        step(-10, -50, 0, 0);
        step(-20, -50, 0, 0);
        step(-50, -50, 0, 0);
        chk("neg_amp", ev_amp, -10);
        chk("neg_ts", ev_ts, 1);
        chk("neg_width", ev_width, 2);
        idle(20, 1);

        // Reset mid-track with a pending event and a lost count
        do_reset();
        pulse(200, 2, 0);
        idle(20, 0);
        pulse(210, 2, 0);
        idle(20, 0);
        chk("mid_lost", lost_cnt, 1);
        step(300, 100, 0, 0);
        step(300, 100, 0, 0);
        step(300, 100, 0, 0);
        step(0, 100, 0, 1);
        chk("mid_valid", ev_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_lost0", lost_cnt, 0);
        chk("mid_amp0", ev_amp, 0);
        pulse(150, 2, 0);
        chk("mid_ts0", ev_ts, 0);
        chk("mid_amp", ev_amp, 150);
        idle(20, 1);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
